// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: bus widths, reset/enable
// levels, chip-enable state encoding and the fetch-address alignment helper.
package inst_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD   = INST_ADDR_W'(0);
    localparam logic [INST_W-1:0]      NOP_WORD    = INST_W'(0);
    localparam logic                   CHIP_ENABLE  = 1'b1;
    localparam logic                   CHIP_DISABLE = 1'b0;
    localparam logic                   RST_ENABLE   = 1'b1;

    // ce state machine encoding
    localparam logic [0:0] CE_HOLD  = 1'b0;
    localparam logic [0:0] CE_FETCH = 1'b1;

    // Word-align a fetch address by clearing the byte offset.
    function automatic logic [INST_ADDR_W-1:0] align_word(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if_id.sv
// IF/ID pipeline register: flush and bubble insert a NOP with id_pc=0,
// a stalled decode holds, otherwise the fetched pc/instruction pair advances.
// With INST_FETCH_ALIGN_CHECK_EN the fetch-misalign flag travels alongside.
module inst_fetch_if_id
    import inst_fetch_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = NOP_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stall_if,
    input  logic                   stall_id,
    input  logic                   ce_i,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0]      inst_i,
`ifdef INST_FETCH_ALIGN_CHECK_EN
    input  logic                   adel_i,
    output logic                   id_adel,
`endif
    output logic [INST_ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0]      id_inst
);

    // IF/ID register with flush > bubble > hold > advance priority
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            id_pc   <= ZERO_WORD;
            id_inst <= NOP_INST;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            id_adel <= 1'b0;
`endif
        end else if (flush || (stall_if && !stall_id)) begin
            id_pc   <= ZERO_WORD;
            id_inst <= NOP_INST;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            id_adel <= 1'b0;
`endif
        end else if (!stall_if) begin
            id_pc   <= pc_i;
            id_inst <= (ce_i == CHIP_ENABLE) ? inst_i : NOP_INST;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            id_adel <= adel_i;
`endif
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives pc/ce to a combinational ROM, resolves
// flush, stall, branch and buffered-branch redirects (delay slot preserved),
// and feeds the IF/ID register. Optional macro INST_FETCH_ALIGN_CHECK_EN adds
// fetch-address alignment and the id_adel output.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = ZERO_WORD,
    parameter logic [INST_W-1:0]      NOP_INST = NOP_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_if,
    input  logic                   stall_id,
    input  logic                   branch_flag,
    input  logic [INST_ADDR_W-1:0] branch_target,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic [INST_W-1:0]      inst_i,
    output logic [INST_ADDR_W-1:0] pc,
    output logic                   ce,
`ifdef INST_FETCH_ALIGN_CHECK_EN
    output logic                   id_adel,
`endif
    output logic [INST_ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0]      id_inst
);

    logic [0:0]             ce_state_q, ce_state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [INST_ADDR_W-1:0] pend_target_q, pend_target_d;
    logic                   adel_q, adel_d;
    logic                   load_en;
    logic [INST_ADDR_W-1:0] load_addr;

    // State registers: ce FSM, pc and the buffered redirect
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            ce_state_q    <= CE_HOLD;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= ZERO_WORD;
            adel_q        <= 1'b0;
        end else begin
            ce_state_q    <= ce_state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            adel_q        <= adel_d;
        end
    end

    // Next state: HOLD->FETCH after reset, then next-pc priority selection
    always_comb begin
        ce_state_d    = ce_state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        adel_d        = adel_q;
        load_en       = 1'b0;
        load_addr     = pc_q;

        case (ce_state_q)
            CE_HOLD: ce_state_d = CE_FETCH;
            default: begin
                if (flush) begin
                    load_en      = 1'b1;
                    load_addr    = new_pc;
                    pend_valid_d = 1'b0;
                end else if (stall_if) begin
                    // A redirect during a stall is remembered, newest wins
                    if (branch_flag) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = branch_target;
                    end
                end else if (branch_flag) begin
                    load_en      = 1'b1;
                    load_addr    = branch_target;
                    pend_valid_d = 1'b0;
                end else if (pend_valid_q) begin
                    load_en      = 1'b1;
                    load_addr    = pend_target_q;
                    pend_valid_d = 1'b0;
                end else begin
                    pc_d   = pc_q + INST_ADDR_W'(4);
                    adel_d = 1'b0;
                end
            end
        endcase

        if (load_en) begin
`ifdef INST_FETCH_ALIGN_CHECK_EN
            pc_d   = align_word(load_addr);
            adel_d = |load_addr[1:0];
`else
            pc_d   = load_addr;
            adel_d = 1'b0;
`endif
        end
    end

    assign pc = pc_q;
    assign ce = (ce_state_q == CE_FETCH) ? CHIP_ENABLE : CHIP_DISABLE;

    inst_fetch_if_id #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .stall_if (stall_if),
        .stall_id (stall_id),
        .ce_i     (ce),
        .pc_i     (pc_q),
        .inst_i   (inst_i),
`ifdef INST_FETCH_ALIGN_CHECK_EN
        .adel_i   (adel_q),
        .id_adel  (id_adel),
`endif
        .id_pc    (id_pc),
        .id_inst  (id_inst)
    );

`ifndef INST_FETCH_ALIGN_CHECK_EN
    logic unused_adel;
    assign unused_adel = adel_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch. The ROM is modelled as
// inst = addr ^ 32'hDEAD_0000 so every fetched word differs from NOP.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] inst_i;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic        id_adel;
`endif

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign inst_i = rom(pc);

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .new_pc        (new_pc),
        .inst_i        (inst_i),
        .pc            (pc),
        .ce            (ce),
`ifdef INST_FETCH_ALIGN_CHECK_EN
        .id_adel       (id_adel),
`endif
        .id_pc         (id_pc),
        .id_inst       (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stall_id without stall_if is an illegal input combination
    always @(posedge clk) begin
        assert (!(stall_id && !stall_if)) else $error("illegal stall_id without stall_if");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; branch_flag = 1'b0;
        branch_target = 32'h0; flush = 1'b0; new_pc = 32'h0;
        tick(); tick();
        checks++; if (ce !== 1'b0) begin errors++; $display("FAIL rst_ce: got %h want %h", ce, 1'b0); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc: got %h want %h", id_pc, 32'h0); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL rst_id_inst: got %h want %h", id_inst, 32'h0); end
        rst = 1'b0;
        tick();
        checks++; if (ce !== 1'b1) begin errors++; $display("FAIL rel_ce: got %h want %h", ce, 1'b1); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rel_pc0: got %h want %h", pc, 32'h0); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL rel_id_inst0: got %h want %h", id_inst, 32'h0); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'(4 * i)); end
            checks++; if (id_pc !== 32'(4 * (i - 1))) begin errors++; $display("FAIL seq_id_pc%0d: got %h want %h", i, id_pc, 32'(4 * (i - 1))); end
            checks++; if (id_inst !== rom(32'(4 * (i - 1)))) begin errors++; $display("FAIL seq_id_inst%0d: got %h want %h", i, id_inst, rom(32'(4 * (i - 1)))); end
        end
    endtask

    task automatic test_branch();
        tick(); tick();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL br_pre_pc: got %h want %h", pc, 32'h14); end
        branch_flag = 1'b1; branch_target = 32'h40;
        tick();
        branch_flag = 1'b0;
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL br_pc: got %h want %h", pc, 32'h40); end
        checks++; if (id_pc !== 32'h14) begin errors++; $display("FAIL br_slot_pc: got %h want %h", id_pc, 32'h14); end
        checks++; if (id_inst !== rom(32'h14)) begin errors++; $display("FAIL br_slot_inst: got %h want %h", id_inst, rom(32'h14)); end
        tick();
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL br_next_pc: got %h want %h", pc, 32'h44); end
        checks++; if (id_inst !== rom(32'h40)) begin errors++; $display("FAIL br_tgt_inst: got %h want %h", id_inst, rom(32'h40)); end
    endtask

    task automatic test_stall_branch();
        stall_if = 1'b1;
        for (int i = 0; i < 3; i++) begin
            branch_flag = (i == 1); branch_target = 32'h80;
            tick();
            checks++; if (pc !== 32'h44) begin errors++; $display("FAIL stall_pc%0d: got %h want %h", i, pc, 32'h44); end
            checks++; if (id_inst !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL stall_bubble%0d: got %h/%h want 0/0", i, id_pc, id_inst); end
        end
        branch_flag = 1'b0; stall_if = 1'b0;
        tick();
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL pend_pc: got %h want %h", pc, 32'h80); end
        checks++; if (id_inst !== rom(32'h44)) begin errors++; $display("FAIL pend_id_inst: got %h want %h", id_inst, rom(32'h44)); end
        tick();
        checks++; if (pc !== 32'h84) begin errors++; $display("FAIL pend_next_pc: got %h want %h", pc, 32'h84); end
    endtask

    task automatic test_flush();
        stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h100;
        tick();
        branch_flag = 1'b0; flush = 1'b1; new_pc = 32'h20;
        tick();
        flush = 1'b0; stall_if = 1'b0;
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL fl_pc: got %h want %h", pc, 32'h20); end
        checks++; if (id_inst !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL fl_nop: got %h/%h want 0/0", id_pc, id_inst); end
        tick();
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL fl_pend_drop: got %h want %h", pc, 32'h24); end
        checks++; if (id_inst !== rom(32'h20)) begin errors++; $display("FAIL fl_id_inst: got %h want %h", id_inst, rom(32'h20)); end
        flush = 1'b1; new_pc = 32'h60; branch_flag = 1'b1; branch_target = 32'h200;
        tick();
        flush = 1'b0; branch_flag = 1'b0;
        checks++; if (pc !== 32'h60) begin errors++; $display("FAIL fl_vs_br_pc: got %h want %h", pc, 32'h60); end
        tick();
        checks++; if (pc !== 32'h64) begin errors++; $display("FAIL fl_vs_br_next: got %h want %h", pc, 32'h64); end
    endtask

    task automatic test_stall_id();
        stall_if = 1'b1; stall_id = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (id_pc !== 32'h60 || id_inst !== rom(32'h60)) begin errors++; $display("FAIL hold%0d: got %h/%h want %h/%h", i, id_pc, id_inst, 32'h60, rom(32'h60)); end
            checks++; if (pc !== 32'h64) begin errors++; $display("FAIL hold_pc%0d: got %h want %h", i, pc, 32'h64); end
        end
        stall_id = 1'b0;
        tick();
        checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0) begin errors++; $display("FAIL hold_bubble: got %h/%h want 0/0", id_pc, id_inst); end
        stall_if = 1'b0;
        tick();
        checks++; if (pc !== 32'h68 || id_pc !== 32'h64) begin errors++; $display("FAIL hold_resume: got %h/%h want %h/%h", pc, id_pc, 32'h68, 32'h64); end
    endtask

    task automatic test_wrap();
        branch_flag = 1'b1; branch_target = 32'hFFFF_FFF8;
        tick();
        branch_flag = 1'b0;
        tick();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre: got %h want %h", pc, 32'hFFFF_FFFC); end
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
        checks++; if (id_inst !== rom(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_inst: got %h want %h", id_inst, rom(32'hFFFF_FFFC)); end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        exp_pc = 32'h40;
`else
        exp_pc = 32'h42;
`endif
        branch_flag = 1'b1; branch_target = 32'h42;
        tick();
        branch_flag = 1'b0;
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL mis_pc: got %h want %h", pc, exp_pc); end
        tick();
        checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL mis_id_pc: got %h want %h", id_pc, exp_pc); end
        checks++; if (pc !== exp_pc + 32'h4) begin errors++; $display("FAIL mis_seq: got %h want %h", pc, exp_pc + 32'h4); end
`ifdef INST_FETCH_ALIGN_CHECK_EN
        checks++; if (id_adel !== 1'b1) begin errors++; $display("FAIL adel_set: got %h want %h", id_adel, 1'b1); end
        tick();
        checks++; if (id_adel !== 1'b0) begin errors++; $display("FAIL adel_clr: got %h want %h", id_adel, 1'b0); end
`endif
    endtask

    task automatic test_reset_mid();
        stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h300;
        tick();
        branch_flag = 1'b0; stall_if = 1'b0; rst = 1'b1;
        tick();
        checks++; if (ce !== 1'b0 || pc !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL mid_rst: got ce=%h pc=%h id_pc=%h want 0/0/0", ce, pc, id_pc); end
        rst = 1'b0;
        tick(); tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL mid_rst_pend: got %h want %h", pc, 32'h4); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall_branch();
        test_flush();
        test_stall_id();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage that generates the PC and chip-enable for the combinational instruction ROM.
- Takes the ROM's returned instruction and registers the PC/instruction pair into the IF/ID pipeline register for the decode stage.
- Handles pipeline stalls, branch redirects with the MIPS delay slot preserved, and exception flush redirects.
- A branch that arrives during a stall is buffered until the stall releases.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0000, instruction word inserted as a bubble or on flush.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- stall_if  in  1  hold PC and IF/ID register.
- stall_id  in  1  decode stalled; stall_id=1 implies stall_if=1.
- branch_flag  in  1  one-cycle branch/jump redirect request from ID.
- branch_target  in  32  redirect address.
- flush  in  1  exception flush from ctrl.
- new_pc  in  32  exception handler / ERET address, valid with flush.
- inst_i  in  32  instruction from ROM, same cycle as pc.
- pc  out  32  fetch address to ROM addr.
- ce  out  1  ROM chip enable.
- id_pc  out  32  registered PC to decode.
- id_inst  out  32  registered instruction to decode.

Behaviour:
- Reset (rst=1 at posedge):
  - ce=0, pc=RESET_PC, id_pc=0, id_inst=NOP_INST.
  - redirect buffer cleared (pend_valid=0, pend_target=0).
- ce state machine, two states:
  - HOLD (ce=0) goes to FETCH on the first posedge with rst=0.
  - FETCH (ce=1) stays in FETCH until rst.
  - The first fetched address is RESET_PC, one cycle after rst deasserts.
  - pc does not advance while ce=0.
- Next-PC priority, applied at posedge when ce=1:
  1. flush: pc<=new_pc, pend_valid<=0. Applies regardless of stall_if.
  2. stall_if=1: pc holds. If branch_flag=1, set pend_valid<=1 and pend_target<=branch_target (newest request overwrites older).
  3. branch_flag=1: pc<=branch_target, pend_valid<=0.
  4. pend_valid=1: pc<=pend_target, pend_valid<=0.
  5. otherwise: pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- No squash on branch: the instruction already in IF is the delay slot and passes to ID normally.
- IF/ID register, updated at posedge:
  - flush: id_pc<=0, id_inst<=NOP_INST.
  - stall_if=1 and stall_id=0: bubble, id_pc<=0, id_inst<=NOP_INST.
  - stall_if=1 and stall_id=1: hold.
  - stall_if=0: id_pc<=pc, id_inst <= (ce ? inst_i : NOP_INST).
- Latency: ROM read is combinational, so an instruction at pc appears on id_inst one cycle later.
- Simultaneous flush and branch_flag: flush wins and the branch is dropped.
- rst mid-operation: all state returns to reset values on that edge, including any buffered redirect.
- stall_id=1 with stall_if=0 is illegal. The bench asserts against it; RTL behaviour for it is unspecified.

Optional Feature:
- Macro: INST_FETCH_ALIGN_CHECK_EN.
- When defined:
  - Adds output id_adel (1 bit, reset 0).
  - Any pc load (new_pc, branch_target, pend_target) with addr[1:0]!=0 loads the address with [1:0] forced to 0 and sets a fetch-misalign flag.
  - The flag travels through IF/ID with id_pc (bubble/flush clear it) and is asserted as id_adel for that instruction.
  - The flag clears on the next sequential pc+4.
- When undefined:
  - No id_adel port.
  - Addresses are loaded verbatim. The ROM indexes by addr[N+1:2], so the low bits are ignored.

Decomposition:
- ZeroWord, NOP_INST, ChipEnable/ChipDisable, RstEnable, InstAddrBus/InstBus widths, and the ce-state encoding go in the shared define include src/define.v.
- One natural sub-module: if_id, the IF/ID pipeline register with the flush/bubble/hold rules. inst_fetch instantiates it.

Test Plan:
- Reset then release: ce=0 during rst; after release pc=0,4,8,C on successive cycles; id_pc lags pc by 1 with matching ROM words.
- Branch at pc=0x10 with branch_target=0x40: next pc=0x40; the delay-slot instruction at 0x14 still reaches id_inst.
- stall_if=1 for 3 cycles with branch_flag pulsed (target 0x80) in stall cycle 2: pc holds, id_inst=NOP each cycle; after release pc=0x80.
- flush with new_pc=0x20 while stall_if=1 and a pending branch exists: pc=0x20, pending discarded, id_inst=NOP.
- stall_if=1 and stall_id=1: id_pc/id_inst held unchanged. Then drop stall_id only: bubble, id_pc=0.
- pc=0xFFFF_FFFC sequential: wraps to 0x0. With INST_FETCH_ALIGN_CHECK_EN, branch_target=0x42 gives pc=0x40 and id_adel=1 for that instruction only.
